// File: rtl/jk_bank_scheduler.sv
// jk_bank_scheduler: round-robin shared JK bit bank.
// One command is latched in ARB and applied to the bank on leaving EXEC.
module jk_bank_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*2-1:0] jk,
  output logic [NREQ-1:0]   gnt,
  output logic              err,
  output logic              busy,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qn
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB, EXEC} state_t;

  state_t state, state_nx;

  logic [PW-1:0]    rr, win, cur, idx;
  logic [AW-1:0]    cur_addr;
  logic [1:0]       cur_jk;
  logic             found, load, fire, in_range;
  logic [WIDTH-1:0] bank, mask;

  // first requester at or above rr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(rr) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    fire     = 1'b0;
    unique case (state)
      ARB: begin
        if (found) begin
          load     = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        fire     = 1'b1;
        state_nx = ARB;
      end
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr       <= '0;
      cur      <= '0;
      cur_addr <= '0;
      cur_jk   <= '0;
    end else if (load) begin
      rr       <= PW'((int'(win) + 1) % NREQ);
      cur      <= win;
      cur_addr <= addr[int'(win)*AW +: AW];
      cur_jk   <= jk[int'(win)*2 +: 2];
    end
  end

  assign in_range = (int'(cur_addr) < WIDTH);
  assign mask     = in_range ? (WIDTH'(1) << cur_addr) : '0;

  // 11 toggles instead of the undefined latch case
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank <= '0;
    end else if (fire) begin
      unique case (cur_jk)
        2'b01:   bank <= bank & ~mask;
        2'b10:   bank <= bank | mask;
        2'b11:   bank <= bank ^ mask;
        default: bank <= bank;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt <= '0;
      err <= 1'b0;
    end else begin
      gnt <= fire ? (NREQ'(1) << cur) : '0;
      err <= fire && !in_range;
    end
  end

  assign busy = (state == EXEC);
  assign q    = bank;
  assign qn   = ~bank;

endmodule
